puf_response_sampler: RTL

Controller sitting directly downstream of the 32-bit arbiter PUF array. It drives the array's challenge word and arbiter clear, and captures the 32-bit response. Each challenge is evaluated NSAMP times, the per-bit results are majority-voted, and the block emits one stabilised response plus an instability mask through a valid/ready handshake. Challenges come from an internal 32-bit LFSR, seeded at start.

---
 rtl/puf_response_sampler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/puf_response_sampler.sv
// Arbiter-PUF response sampler: evaluates each LFSR challenge NSAMP times,
// majority-votes each bit and hands out response, instability mask and challenge.
module puf_response_sampler #(
    parameter int NSAMP      = 5,
    parameter int CLR_CYC    = 2,
    parameter int SETTLE_CYC = 4,
    parameter int N_CHAL     = 16
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] seed,
    output logic [31:0] puf_C,
    output logic        puf_clr,
    input  logic [31:0] puf_O,
    output logic [31:0] resp,
    output logic [31:0] resp_mask,
    output logic [31:0] resp_chal,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(NSAMP + 1);
    localparam logic [CW-1:0] CNT_ALL  = CW'(NSAMP);
    localparam logic [CW-1:0] CNT_HALF = CW'(NSAMP / 2);
    localparam logic [15:0]   TMR_CLR  = 16'(CLR_CYC - 1);
    localparam logic [15:0]   TMR_SET  = 16'(SETTLE_CYC - 1);
    localparam logic [3:0]    LAST_SMP = 4'(NSAMP - 1);
    localparam logic [15:0]   LAST_CHL = 16'(N_CHAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETTLE,
        S_SAMPLE,
        S_DONE_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     tmr_q, tmr_d;
    logic [3:0]      sample_idx_q, sample_idx_d;
    logic [15:0]     chal_idx_q, chal_idx_d;
    logic [31:0]     puf_c_q, puf_c_d;
    logic [CW-1:0]   cnt_q [32];
    logic [CW-1:0]   cnt_d [32];
    logic [31:0]     resp_q, resp_d;
    logic [31:0]     mask_q, mask_d;
    logic [31:0]     chal_q, chal_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    function automatic logic [31:0] lfsr_step(input logic [31:0] c);
        return {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
    endfunction

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        sample_idx_d = sample_idx_q;
        chal_idx_d   = chal_idx_q;
        puf_c_d      = puf_c_q;
        cnt_d        = cnt_q;
        resp_d       = resp_q;
        mask_d       = mask_q;
        chal_d       = chal_q;
        valid_d      = valid_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    puf_c_d      = (seed == 32'h0) ? 32'h0000_0001 : seed;
                    sample_idx_d = '0;
                    chal_idx_d   = '0;
                    for (int i = 0; i < 32; i++) cnt_d[i] = '0;
                    tmr_d        = TMR_CLR;
                    state_d      = S_ARM;
                end
            end
            S_ARM: begin
                if (tmr_q == 16'h0) begin
                    tmr_d   = TMR_SET;
                    state_d = S_SETTLE;
                end else begin
                    tmr_d = tmr_q - 16'h1;
                end
            end
            S_SETTLE: begin
                if (tmr_q == 16'h0) begin
                    state_d = S_SAMPLE;
                end else begin
                    tmr_d = tmr_q - 16'h1;
                end
            end
            S_SAMPLE: begin
                for (int i = 0; i < 32; i++) cnt_d[i] = cnt_q[i] + CW'(puf_O[i]);
                if (sample_idx_q == LAST_SMP) begin
                    // Vote on the counts that already include this final sample.
                    for (int i = 0; i < 32; i++) begin
                        resp_d[i] = (cnt_d[i] > CNT_HALF);
                        mask_d[i] = (cnt_d[i] != '0) && (cnt_d[i] != CNT_ALL);
                    end
                    chal_d  = puf_c_q;
                    valid_d = 1'b1;
                    state_d = S_DONE_WAIT;
                end else begin
                    sample_idx_d = sample_idx_q + 4'h1;
                    tmr_d        = TMR_CLR;
                    state_d      = S_ARM;
                end
            end
            S_DONE_WAIT: begin
                if (valid_q && resp_ready) begin
                    valid_d = 1'b0;
                    if (chal_idx_q == LAST_CHL) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        chal_idx_d   = chal_idx_q + 16'h1;
                        puf_c_d      = lfsr_step(puf_c_q);
                        sample_idx_d = '0;
                        for (int i = 0; i < 32; i++) cnt_d[i] = '0;
                        tmr_d        = TMR_CLR;
                        state_d      = S_ARM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            sample_idx_q <= '0;
            chal_idx_q   <= '0;
            puf_c_q      <= '0;
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
            resp_q       <= '0;
            mask_q       <= '0;
            chal_q       <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            sample_idx_q <= sample_idx_d;
            chal_idx_q   <= chal_idx_d;
            puf_c_q      <= puf_c_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
            mask_q       <= mask_d;
            chal_q       <= chal_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
        end
    end

    assign puf_C      = puf_c_q;
    assign puf_clr    = !((state_q == S_SETTLE) || (state_q == S_SAMPLE));
    assign resp       = resp_q;
    assign resp_mask  = mask_q;
    assign resp_chal  = chal_q;
    assign resp_valid = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

endmodule
